// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and constants for the two-port data memory arbiter.
package data_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam logic [31:0] WORD_ZERO = 32'h0000_0000;

  // Mask that keeps only the address bits the memory actually decodes.
  function automatic logic [31:0] addr_mask(input int unsigned bits);
    if (bits >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << bits) - 32'd1;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: combinational one-hot grant plus a registered
// priority pointer that moves to the port that was not just served.
module data_mem_arbiter_rr_arbiter2
  import data_mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       update_i,
  input  logic       last_port_i,
  output logic [1:0] grant_o
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    // NOTE: default first so every path assigns grant_o and no latch is inferred.
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = (ptr_q == PORT1) ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

  assign ptr_d = update_i ? ~last_port_i : ptr_q;

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) ptr_q <= PORT0;
    else      ptr_q <= ptr_d;
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates two requesters onto one byte-addressed data memory with a fixed
// IDLE -> ACCESS -> RESP sequence, round-robin grant and alignment checking.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_BITS   = 16,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        busy,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic        mem_read,
  output logic        mem_write
);

  localparam logic [31:0] ADDR_MASK = addr_mask(ADDR_BITS);

  state_e      state_q;
  logic        port_q;
  logic        we_q;
  logic        misalign_q;
  logic        ack0_q, ack1_q;
  logic        err0_q, err1_q;
  logic [31:0] rdata0_q, rdata1_q;
  logic        busy_q;
  logic        mem_read_q, mem_write_q;
  logic [31:0] mem_address_q;
  logic [31:0] mem_write_data_q;

  logic [1:0]  grant;
  logic        sel_port;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_misalign;

  data_mem_arbiter_rr_arbiter2 u_rr (
    .clk         (clk),
    .rst         (rst),
    .req_i       ({req1, req0}),
    .update_i    (state_q == ST_RESP),
    .last_port_i (port_q),
    .grant_o     (grant)
  );

  assign sel_port     = grant[1];
  assign sel_we       = sel_port ? we1    : we0;
  assign sel_addr     = sel_port ? addr1  : addr0;
  assign sel_wdata    = sel_port ? wdata1 : wdata0;
  assign sel_misalign = CHECK_ALIGN && (sel_addr[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q          <= ST_IDLE;
      port_q           <= PORT0;
      we_q             <= 1'b0;
      misalign_q       <= 1'b0;
      ack0_q           <= 1'b0;
      ack1_q           <= 1'b0;
      err0_q           <= 1'b0;
      err1_q           <= 1'b0;
      rdata0_q         <= WORD_ZERO;
      rdata1_q         <= WORD_ZERO;
      busy_q           <= 1'b0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_address_q    <= WORD_ZERO;
      mem_write_data_q <= WORD_ZERO;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant != 2'b00) begin
            port_q           <= sel_port;
            we_q             <= sel_we;
            misalign_q       <= sel_misalign;
            mem_address_q    <= sel_addr & ADDR_MASK;
            mem_write_data_q <= sel_wdata;
            // A rejected access never strobes the memory.
            mem_write_q      <= sel_we & ~sel_misalign;
            mem_read_q       <= ~sel_we & ~sel_misalign;
            busy_q           <= 1'b1;
            state_q          <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          if (port_q == PORT1) begin
            ack1_q <= 1'b1;
            err1_q <= misalign_q;
            if (misalign_q)  rdata1_q <= WORD_ZERO;
            else if (!we_q)  rdata1_q <= mem_read_data;
          end else begin
            ack0_q <= 1'b1;
            err0_q <= misalign_q;
            if (misalign_q)  rdata0_q <= WORD_ZERO;
            else if (!we_q)  rdata0_q <= mem_read_data;
          end
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          err0_q  <= 1'b0;
          err1_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ack0           = ack0_q;
  assign ack1           = ack1_q;
  assign err0           = err0_q;
  assign err1           = err1_q;
  assign rdata0         = rdata0_q;
  assign rdata1         = rdata1_q;
  assign busy           = busy_q;
  assign mem_address    = mem_address_q;
  assign mem_write_data = mem_write_data_q;
  assign mem_read       = mem_read_q;
  // Reset is synchronous, so the write strobe is gated directly to stop a
  // commit at an edge where reset is asserted mid-access.
  assign mem_write      = mem_write_q & rst;

  a_no_rw_overlap: assert property (@(posedge clk) disable iff (!rst)
    !(mem_read_q && mem_write_q));
  a_strobe_in_access: assert property (@(posedge clk) disable iff (!rst)
    (mem_read_q || mem_write_q) |-> (state_q == ST_ACCESS));
  a_single_ack: assert property (@(posedge clk) disable iff (!rst)
    !(ack0_q && ack1_q));

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter with a big-endian byte memory model.
module tb_data_mem_arbiter;

  logic        clk, rst;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic        busy;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_read, mem_write;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int wr_cycles = 0;
  int overlap   = 0;
  int err_viol  = 0;

  typedef struct {
    logic        port;
    logic        hold;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] cur_rd [2];
  logic [31:0] acc_addr;
  logic [7:0]  mem_b [0:65535];
  logic [15:0] ma;

  data_mem_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .req0           (req0),
    .req1           (req1),
    .we0            (we0),
    .we1            (we1),
    .addr0          (addr0),
    .addr1          (addr1),
    .wdata0         (wdata0),
    .wdata1         (wdata1),
    .ack0           (ack0),
    .ack1           (ack1),
    .err0           (err0),
    .err1           (err1),
    .rdata0         (rdata0),
    .rdata1         (rdata1),
    .busy           (busy),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .mem_read       (mem_read),
    .mem_write      (mem_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: byte at addr is the MSB, combinational read, write on posedge.
  assign ma = mem_address[15:0];
  assign mem_read_data = mem_read ?
    {mem_b[ma], mem_b[ma + 16'd1], mem_b[ma + 16'd2], mem_b[ma + 16'd3]} : 32'h0;

  always @(posedge clk) begin
    if (mem_write) begin
      mem_b[ma]         <= mem_write_data[31:24];
      mem_b[ma + 16'd1] <= mem_write_data[23:16];
      mem_b[ma + 16'd2] <= mem_write_data[15:8];
      mem_b[ma + 16'd3] <= mem_write_data[7:0];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push(input logic port, input logic hold, input logic err, input logic [31:0] rd);
    exp_t e;
    e.port = port; e.hold = hold; e.err = err; e.rdata = rd;
    sb.push_back(e);
  endtask

  task automatic drive(input logic port, input logic we, input logic [31:0] a, input logic [31:0] d);
    if (port) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    else      begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
  endtask

  // Called just after the grant edge: ack is expected on the second negedge.
  task automatic wait_ack(input logic port, input string name);
    int lat = 0;
    bit got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (i == 0) acc_addr = mem_address;
      if (port ? ack1 : ack0) got = 1;
    end
    check(name, lat, 2);
  endtask

  task automatic single(input logic port, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input string name);
    drive(port, we, a, d);
    @(posedge clk); #1;
    if (port) req1 = 1'b0; else req0 = 1'b0;
    wait_ack(port, name);
    @(posedge clk); #1;
  endtask

  // Both ports request together with port 0 holding priority.
  task automatic dual(input string name0, input string name1);
    @(posedge clk); #1;
    req0 = 1'b0;
    wait_ack(1'b0, name0);
    @(posedge clk);
    @(posedge clk); #1;
    req1 = 1'b0;
    wait_ack(1'b1, name1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // Monitor: pops the scoreboard on every ack and tracks held rdata.
  exp_t        mon_e;
  logic        mon_p;
  logic [31:0] mon_rd;
  always @(negedge clk) begin
    if (mem_read && mem_write) overlap++;
    if ((err0 && !ack0) || (err1 && !ack1)) err_viol++;
    if (mem_write) wr_cycles++;
    if (!rst) begin
      cur_rd[0] = 32'h0;
      cur_rd[1] = 32'h0;
    end else if (ack0 || ack1) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", {30'b0, ack1, ack0}, 32'h0);
      end else begin
        mon_e  = sb.pop_front();
        mon_p  = mon_e.port;
        mon_rd = mon_e.hold ? cur_rd[mon_p] : mon_e.rdata;
        check("sb_ack_port", {30'b0, ack1, ack0}, mon_p ? 32'd2 : 32'd1);
        check("sb_err", mon_p ? err1 : err0, mon_e.err);
        check("sb_rdata", mon_p ? rdata1 : rdata0, mon_rd);
        check("sb_other_rdata_hold", mon_p ? rdata0 : rdata1, cur_rd[~mon_p]);
        check("sb_other_err_zero", mon_p ? err0 : err1, 32'h0);
        cur_rd[mon_p] = mon_rd;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog expired");
  end

  int wr0;

  initial begin
    for (int i = 0; i < 65536; i++) mem_b[i] = i[7:0] ^ 8'hA5;
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 32'h0; addr1 = 32'h0; wdata0 = 32'h0; wdata1 = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_ctrl", {ack0, ack1, err0, err1, busy, mem_read, mem_write}, 32'h0);
    check("rst_rdata0", rdata0, 32'h0);
    check("rst_rdata1", rdata1, 32'h0);
    check("rst_mem_address", mem_address, 32'h0);
    @(posedge clk); #1;

    // Port 0 write then read at 4
    wr0 = wr_cycles;
    push(1'b0, 1'b1, 1'b0, 32'h0);
    single(1'b0, 1'b1, 32'h4, 32'h0000_FFFF, "t1_wr_lat");
    check("t1_wr_cycles", wr_cycles - wr0, 1);
    push(1'b0, 1'b0, 1'b0, 32'h0000_FFFF);
    single(1'b0, 1'b0, 32'h4, 32'h0, "t1_rd_lat");

    // Simultaneous requests: port 0 reads old value, then port 1 writes
    do_reset();
    push(1'b0, 1'b0, 1'b0, 32'h8988_8B8A);
    push(1'b1, 1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 32'd44, 32'h0);
    drive(1'b1, 1'b1, 32'd44, 32'hFFFF_0000);
    dual("t2_p0_lat", "t2_p1_lat");
    push(1'b0, 1'b0, 1'b0, 32'hFFFF_0000);
    single(1'b0, 1'b0, 32'd44, 32'h0, "t2_rd_new_lat");

    // Both requests held for six accesses: strict alternation
    do_reset();
    for (int i = 0; i < 6; i++)
      push(i[0], 1'b0, 1'b0, i[0] ? 32'hFFFF_0000 : 32'h0000_FFFF);
    drive(1'b0, 1'b0, 32'h4, 32'h0);
    drive(1'b1, 1'b0, 32'd44, 32'h0);
    for (int k = 0; k <= 18; k++) begin
      @(negedge clk);
      check("t3_busy", busy, (k % 3 != 0) ? 32'h1 : 32'h0);
      check("t3_ack_spacing", ack0 | ack1, (k % 3 == 2) ? 32'h1 : 32'h0);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    @(posedge clk); #1;

    // Misaligned port 1 write is rejected and memory is untouched
    wr0 = wr_cycles;
    push(1'b1, 1'b0, 1'b1, 32'h0);
    single(1'b1, 1'b1, 32'h0000_000E, 32'h1234_5678, "t4_mis_lat");
    check("t4_mis_no_write", wr_cycles - wr0, 0);
    push(1'b0, 1'b0, 1'b0, 32'hA9A8_ABAA);
    single(1'b0, 1'b0, 32'd12, 32'h0, "t4_rd12_lat");

    // Reset during the ACCESS cycle of a write at 8
    wr0 = wr_cycles;
    drive(1'b0, 1'b1, 32'h8, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    req0 = 1'b0;
    rst  = 1'b0;
    @(negedge clk);
    check("t5_mem_write_gated", mem_write, 32'h0);
    check("t5_busy_in_access", busy, 32'h1);
    @(negedge clk);
    check("t5_ctrl_zero", {ack0, ack1, err0, err1, busy, mem_read, mem_write}, 32'h0);
    check("t5_rdata0_zero", rdata0, 32'h0);
    check("t5_addr_zero", mem_address, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("t5_idle", busy, 32'h0);
    check("t5_no_write", wr_cycles - wr0, 0);
    @(posedge clk); #1;

    // Pointer back at port 0; port 1 read exercises the address wrap
    push(1'b0, 1'b0, 1'b0, 32'hADAC_AFAE);
    push(1'b1, 1'b0, 1'b0, 32'hB5B4_B7B6);
    drive(1'b0, 1'b0, 32'h8, 32'h0);
    drive(1'b1, 1'b0, 32'h0001_0010, 32'h0);
    dual("t6_p0_lat", "t6_p1_lat");
    check("t6_wrap_addr", acc_addr, 32'h0000_0010);

    check("sb_drained", sb.size(), 32'h0);
    check("rw_overlap", overlap, 32'h0);
    check("err_without_ack", err_viol, 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single byte-addressed data memory between two requesters: port 0 is the CPU MEM stage, port 1 is the loader/debug port.
- Uses a req/ack handshake, round-robin arbitration, a fixed 3-state access sequence and alignment checking.
- Sits between the requesters and the data memory's address/write_data/read_data/mem_read/mem_write/clk interface.
- Memory words are big-endian: byte at addr is the MSB. Writes commit on posedge; reads are combinational while mem_read=1.

Parameters:
- ADDR_BITS, 16: address bits forwarded to memory. Upper bits of mem_address are driven 0.
- CHECK_ALIGN, 1: when 1, addr[1:0]!=0 is rejected with err.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset.
- req0, req1  in  1  access request from port 0 / port 1.
- we0, we1  in  1  1=write, 0=read.
- addr0, addr1  in  32  byte address.
- wdata0, wdata1  in  32  write data.
- ack0, ack1  out  1  one-cycle completion pulse.
- err0, err1  out  1  valid with ack; access was rejected.
- rdata0, rdata1  out  32  read result; valid with ack.
- busy  out  1  arbiter not in IDLE.
- mem_address  out  32  to memory address.
- mem_write_data  out  32  to memory write_data.
- mem_read_data  in  32  from memory read_data.
- mem_read, mem_write  out  1  memory strobes.

Behaviour:
- Reset (rst=0 at posedge):
  - State goes to IDLE; priority pointer to port 0.
  - ack*, err*, busy, mem_read and mem_write go to 0; rdata* and mem_address go to 32'b0.
  - mem_write is additionally ANDed combinationally with rst, so no write commits at an edge where rst=0. This also covers reset arriving during ACCESS.
- States and transitions:
  - IDLE: if any req is high, grant per the round-robin rule, latch the winner's we/addr/wdata, and go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: held for exactly 1 cycle.
    - mem_address = {zeros, latched addr[ADDR_BITS-1:0]}.
    - Write: mem_write=1, mem_write_data=latched wdata; the write commits at the closing edge.
    - Read: mem_read=1; mem_read_data is captured into the winner's rdata at the closing edge.
    - Next state is RESP.
  - RESP: ack of the winner =1 for exactly 1 cycle, err valid; then go to IDLE. The priority pointer moves to the other port at this edge.
- Round-robin rule: if only one req is high, that port wins. If both are high, the pointer port wins. Back-to-back requests from both ports therefore alternate 0,1,0,1.
- Latency: req sampled at edge N; ACCESS during cycle N+1; ack high during cycle N+2. Throughput is 1 access per 3 cycles.
- Handshake:
  - Requester holds req and its fields until the grant edge. Fields may change afterwards.
  - req is ignored in ACCESS/RESP.
  - Requester must drop req in the cycle after seeing ack, or it is treated as a new request.
  - The losing requester's req stays pending with no timeout.
- Alignment: with CHECK_ALIGN=1 and latched addr[1:0]!=0, the ACCESS cycle keeps mem_read=mem_write=0. The winner then gets ack with err=1 and rdata=32'b0; memory is untouched.
- Outputs:
  - rdata of the non-winning port holds its last value.
  - err is 0 whenever ack is 0.
  - busy=1 in ACCESS and RESP.
- Addresses above 2**ADDR_BITS wrap: only the low ADDR_BITS are forwarded, no error.
- mem_read and mem_write are never 1 simultaneously, and never 1 outside ACCESS.

Decomposition:
- Add to constant_values.vh: state encodings (IDLE=2'b00, ACCESS=2'b01, RESP=2'b10), port indices, and reuse of WORD_ZERO and Z.
- One natural sub-module: rr_arbiter2. Inputs req[1:0], current pointer and an update strobe; outputs a one-hot grant. It is combinational grant logic plus the registered pointer.

Test Plan:
- Port 0 write 0x0000FFFF @4, then port 0 read @4:
  - ack0 at req edge+2 both times.
  - mem_write high exactly 1 cycle.
  - rdata0=0x0000FFFF, err0=0.
- Both ports request on the same edge:
  - Port 1 writes 0xFFFF0000 @44; port 0 reads @44.
  - Port 0 is served first and reads the old value.
  - Port 1 is acked 3 cycles later.
  - A following port 0 read returns 0xFFFF0000.
- Both req held high for 6 accesses:
  - Grants alternate 0,1,0,1,0,1.
  - ack pulses are spaced 3 cycles apart; busy drops only after the last RESP.
- Port 1 write @0x0000_000E (misaligned):
  - ack1 with err1=1 and rdata1=0.
  - mem_write never asserts; a later read @12 returns the prior contents.
- rst=0 asserted during the ACCESS cycle of a write @8:
  - No write commits; state returns to IDLE.
  - No ack occurs, all outputs are zeroed, and the pointer returns to port 0.
- Address 0x0001_0010 read:
  - mem_address=0x0000_0010 and err=0, confirming the ADDR_BITS wrap.
